// File: rtl/sw_pe_cfg_if.sv
// Port bundle for one Smith-Waterman processing element: score configuration,
// the systolic inputs from the upstream PE and the registered outputs to the next one.
interface sw_pe_cfg_if #(
  parameter int WIDTH = 20,
  parameter int SYM_W = 2,
  parameter int POS_W = 16
);
  // No valid/ready handshake: init_in qualifies each column, last_in marks the final
  // column, and every output is a one-cycle registered copy with the same framing.
  logic                    cfg_we;
  logic [1:0]              cfg_addr;
  logic signed [7:0]       cfg_data;
  logic                    mode_local;
  logic signed [WIDTH-1:0] V_in;
  logic signed [WIDTH-1:0] F_in;
  logic [SYM_W-1:0]        T_in;
  logic [SYM_W-1:0]        S_in;
  logic                    store_S;
  logic                    init_in;
  logic                    last_in;
  logic signed [WIDTH-1:0] max_in;
  logic [POS_W-1:0]        pos_in;
  logic signed [WIDTH-1:0] V_out;
  logic signed [WIDTH-1:0] F_out;
  logic [SYM_W-1:0]        T_out;
  logic                    init_out;
  logic                    last_out;
  logic signed [WIDTH-1:0] max_out;
  logic [POS_W-1:0]        pos_out;

  modport master (
    output cfg_we, cfg_addr, cfg_data, mode_local, V_in, F_in, T_in, S_in, store_S,
           init_in, last_in, max_in, pos_in,
    input  V_out, F_out, T_out, init_out, last_out, max_out, pos_out
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, mode_local, V_in, F_in, T_in, S_in, store_S,
           init_in, last_in, max_in, pos_in,
    output V_out, F_out, T_out, init_out, last_out, max_out, pos_out
  );
endinterface

// File: rtl/sw_pe_cfg.sv
// Smith-Waterman PE with affine gaps and runtime-writable scores; tracks its best
// cell and merges it with the upstream best on the final reference column.
module sw_pe_cfg #(
  parameter int WIDTH = 20,
  parameter int SYM_W = 2,
  parameter int POS_W = 16,
  parameter logic signed [7:0] MATCH_DEF    = 8'sd2,
  parameter logic signed [7:0] MISMATCH_DEF = -8'sd2,
  parameter logic signed [7:0] GAP_OPEN_DEF = -8'sd2,
  parameter logic signed [7:0] GAP_EXT_DEF  = -8'sd1
) (
  input logic         clk,
  input logic         rst,
  sw_pe_cfg_if.slave  pe
);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [7:0] b);
    logic [WIDTH:0] sum;
    sum = {a[WIDTH-1], a} + {{(WIDTH-7){b[7]}}, b};
    if (sum[WIDTH] != sum[WIDTH-1]) sat_add = sum[WIDTH] ? SMIN : SMAX;
    else sat_add = sum[WIDTH-1:0];
  endfunction

  logic signed [7:0]       match_q, mism_q, gopen_q, gext_q;
  logic signed [WIDTH-1:0] v_q, e_q, f_q, vdiag_q, best_q, max_q;
  logic [SYM_W-1:0]        s_q, t_q;
  logic                    init_q, last_q;
  logic [POS_W-1:0]        col_q, best_pos_q, pos_q;

  logic signed [WIDTH-1:0] h_d, e_d, f_d, v_d, best_d, max_d, best_base;
  logic signed [WIDTH-1:0] e_open, e_ext, f_open, f_ext;
  logic [POS_W-1:0]        col_d, best_pos_d, pos_d, pos_base;

  always_comb begin
    h_d    = sat_add(vdiag_q, (s_q == pe.T_in) ? match_q : mism_q);
    e_open = sat_add(v_q, gopen_q);
    e_ext  = sat_add(e_q, gext_q);
    f_open = sat_add(pe.V_in, gopen_q);
    f_ext  = sat_add(pe.F_in, gext_q);
    e_d    = (e_open > e_ext) ? e_open : e_ext;
    f_d    = (f_open > f_ext) ? f_open : f_ext;

    if (pe.mode_local && e_d[WIDTH-1] && f_d[WIDTH-1] && h_d[WIDTH-1]) v_d = '0;
    else if (e_d > f_d && e_d > h_d) v_d = e_d;
    else if (f_d > h_d) v_d = f_d;
    else v_d = h_d;

    // A column with init_q low is the first of a pass: column index and best restart.
    col_d     = init_q ? col_q + 1'b1 : '0;
    best_base = init_q ? best_q : '0;
    pos_base  = init_q ? best_pos_q : '0;
    best_d     = best_q;
    best_pos_d = best_pos_q;
    if (pe.init_in) begin
      best_d     = (v_d > best_base) ? v_d : best_base;
      best_pos_d = (v_d > best_base) ? col_d : pos_base;
    end

    max_d = max_q;
    pos_d = pos_q;
    if (pe.last_in) begin
      max_d = (pe.max_in > best_d) ? pe.max_in : best_d;
      pos_d = (pe.max_in > best_d) ? pe.pos_in : best_pos_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q    <= MATCH_DEF;
      mism_q     <= MISMATCH_DEF;
      gopen_q    <= GAP_OPEN_DEF;
      gext_q     <= GAP_EXT_DEF;
      v_q        <= '0;
      e_q        <= '0;
      f_q        <= '0;
      vdiag_q    <= '0;
      s_q        <= '0;
      t_q        <= '0;
      init_q     <= 1'b0;
      last_q     <= 1'b0;
      col_q      <= '0;
      best_q     <= '0;
      best_pos_q <= '0;
      max_q      <= '0;
      pos_q      <= '0;
    end else begin
      t_q     <= pe.T_in;
      init_q  <= pe.init_in;
      last_q  <= pe.last_in;
      vdiag_q <= pe.V_in;
      max_q   <= max_d;
      pos_q   <= pos_d;
      if (pe.store_S) s_q <= pe.S_in;
      if (pe.cfg_we) begin
        case (pe.cfg_addr)
          2'd0: match_q <= pe.cfg_data;
          2'd1: mism_q  <= pe.cfg_data;
          2'd2: gopen_q <= pe.cfg_data;
          2'd3: gext_q  <= pe.cfg_data;
        endcase
      end
      if (pe.init_in) begin
        v_q        <= v_d;
        e_q        <= e_d;
        f_q        <= f_d;
        col_q      <= col_d;
        best_q     <= best_d;
        best_pos_q <= best_pos_d;
      end else begin
        v_q <= '0;
        e_q <= '0;
        f_q <= '0;
      end
    end
  end

  assign pe.V_out    = v_q;
  assign pe.F_out    = f_q;
  assign pe.T_out    = t_q;
  assign pe.init_out = init_q;
  assign pe.last_out = last_q;
  assign pe.max_out  = max_q;
  assign pe.pos_out  = pos_q;
endmodule

// File: tb/tb_sw_pe_cfg.sv
// Bench for sw_pe_cfg: directed scenarios followed by random traffic, each cycle
// checked against an integer-arithmetic model of the alignment recurrence.
module tb_sw_pe_cfg;
  localparam int WIDTH = 20;
  localparam int SYM_W = 2;
  localparam int POS_W = 16;
  localparam longint LIM = longint'(1) << (WIDTH - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sw_pe_cfg_if #(.WIDTH(WIDTH), .SYM_W(SYM_W), .POS_W(POS_W)) pe ();
  sw_pe_cfg #(.WIDTH(WIDTH), .SYM_W(SYM_W), .POS_W(POS_W)) dut (.clk(clk), .rst(rst), .pe(pe));

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  longint m_v, m_e, m_f, m_vd, m_best, m_bpos, m_max, m_pos, m_col;
  longint m_sc[4];
  int     m_s, m_t;
  bit     m_init, m_last;

  function automatic longint sat(input longint x);
    if (x > LIM - 1) return LIM - 1;
    if (x < -LIM) return -LIM;
    return x;
  endfunction

  function automatic longint max2(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the cell score is the best of the diagonal, up and left candidates,
  // floored at zero in local mode; columns and best are counted per pass.
  task automatic model_step();
    longint h, ne, nf, nv, b, bp;
    if (rst) begin
      m_v = 0; m_e = 0; m_f = 0; m_vd = 0; m_best = 0; m_bpos = 0;
      m_max = 0; m_pos = 0; m_col = 0; m_s = 0; m_t = 0; m_init = 0; m_last = 0;
      m_sc = '{2, -2, -2, -1};
    end else begin
      h  = sat(m_vd + ((m_s == int'(pe.T_in)) ? m_sc[0] : m_sc[1]));
      ne = max2(sat(m_v + m_sc[2]), sat(m_e + m_sc[3]));
      nf = max2(sat(longint'(pe.V_in) + m_sc[2]), sat(longint'(pe.F_in) + m_sc[3]));
      nv = max2(h, max2(ne, nf));
      if (pe.mode_local) nv = max2(nv, 0);
      b = m_best;
      bp = m_bpos;
      if (pe.init_in) begin
        m_col = m_init ? (m_col + 1) % (longint'(1) << POS_W) : 0;
        if (!m_init) begin b = 0; bp = 0; end
        if (nv > b) begin b = nv; bp = m_col; end
        m_v = nv; m_e = ne; m_f = nf;
      end else begin
        m_v = 0; m_e = 0; m_f = 0;
      end
      m_best = b;
      m_bpos = bp;
      if (pe.last_in) begin
        if (longint'(pe.max_in) > b) begin m_max = longint'(pe.max_in); m_pos = longint'(pe.pos_in); end
        else begin m_max = b; m_pos = bp; end
      end
      m_vd = longint'(pe.V_in);
      if (pe.store_S) m_s = int'(pe.S_in);
      m_t = int'(pe.T_in);
      m_init = pe.init_in;
      m_last = pe.last_in;
      if (pe.cfg_we) m_sc[pe.cfg_addr] = longint'(pe.cfg_data);
    end
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] ev;
    ev = exp_q.pop_front();
    chk("v_out", pe.V_out, $signed(ev));
    chk("f_out", pe.F_out, m_f);
    chk("t_out", pe.T_out, m_t);
    chk("init_out", pe.init_out, m_init);
    chk("last_out", pe.last_out, m_last);
    chk("max_out", pe.max_out, m_max);
    chk("pos_out", pe.pos_out, m_pos);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    exp_q.push_back(m_v[WIDTH-1:0]);
    #1;
    check_all();
  endtask

  task automatic idle();
    pe.cfg_we = 0; pe.cfg_addr = 0; pe.cfg_data = 0; pe.mode_local = 1;
    pe.V_in = 0; pe.F_in = 0; pe.T_in = 0; pe.S_in = 0; pe.store_S = 0;
    pe.init_in = 0; pe.last_in = 0; pe.max_in = 0; pe.pos_in = 0;
  endtask

  initial begin
    idle();
    rst = 1; step(); step();
    chk("rst_v", pe.V_out, 0);
    chk("rst_max", pe.max_out, 0);
    rst = 0;

    // Local pass, S=A, T = A C A, then two final-column merges.
    pe.S_in = 0; pe.store_S = 1; step(); pe.store_S = 0;
    pe.init_in = 1; pe.T_in = 0; step(); chk("loc_c0", pe.V_out, 2);
    pe.T_in = 1; step(); chk("loc_c1", pe.V_out, 0);
    pe.T_in = 0; step(); chk("loc_c2", pe.V_out, 2);
    pe.T_in = 1; pe.last_in = 1; pe.max_in = 5; pe.pos_in = 7; step();
    chk("up_max", pe.max_out, 5); chk("up_pos", pe.pos_out, 7);
    pe.max_in = 1; pe.pos_in = 9; step();
    chk("own_max", pe.max_out, 2); chk("own_pos", pe.pos_out, 0);
    pe.last_in = 0; pe.init_in = 0; step(); chk("max_hold", pe.max_out, 2);

    // Own best 9 at column 3 beats upstream 5.
    pe.init_in = 1; pe.T_in = 1; step(); step();
    pe.V_in = 7; step();
    pe.V_in = 0; pe.T_in = 0; step(); chk("c3_v", pe.V_out, 9);
    pe.T_in = 1; pe.last_in = 1; pe.max_in = 5; pe.pos_in = 7; step();
    chk("best9_max", pe.max_out, 9); chk("best9_pos", pe.pos_out, 3);
    pe.last_in = 0; pe.init_in = 0; step();

    // Mismatch from zero state: global gives -1, local clamps to 0.
    pe.mode_local = 0; pe.init_in = 1; step(); chk("glob_v", pe.V_out, -1);
    pe.init_in = 0; step();
    pe.mode_local = 1; pe.init_in = 1; step(); chk("loc_clamp", pe.V_out, 0);
    pe.init_in = 0; step();

    // Saturation at both rails.
    pe.mode_local = 0; pe.V_in = 20'(LIM - 2); step();
    pe.init_in = 1; pe.T_in = 0; pe.V_in = 0; step(); chk("sat_pos", pe.V_out, LIM - 1);
    pe.V_in = 20'(-LIM); pe.F_in = 20'(-LIM); pe.T_in = 1; step(); chk("sat_neg_f", pe.F_out, -LIM);
    pe.V_in = 0; pe.F_in = 0; pe.init_in = 0; step();

    // Mid-pass match rewrite, then a write coinciding with the last column.
    pe.mode_local = 1; pe.init_in = 1; pe.T_in = 1; pe.V_in = 3;
    pe.cfg_we = 1; pe.cfg_addr = 0; pe.cfg_data = 5; step();
    pe.cfg_we = 0; pe.T_in = 0; pe.V_in = 10; step(); chk("cfg_mid", pe.V_out, 8);
    pe.V_in = 0; pe.cfg_we = 1; pe.cfg_data = 2; pe.last_in = 1; pe.max_in = 0; step();
    chk("cfg_last_v", pe.V_out, 15); chk("cfg_last_max", pe.max_out, 15); chk("cfg_last_pos", pe.pos_out, 2);
    pe.cfg_we = 0; pe.last_in = 0;

    // Reset mid-pass overriding a write, then default scores in effect.
    pe.cfg_we = 1; pe.cfg_data = 7; pe.last_in = 1; pe.max_in = 99; rst = 1; step();
    chk("mid_rst_v", pe.V_out, 0); chk("mid_rst_max", pe.max_out, 0); chk("mid_rst_init", pe.init_out, 0);
    rst = 0; idle(); step();
    pe.init_in = 1; pe.T_in = 0; step();
    chk("def_match", pe.V_out, 2); chk("def_gap", pe.F_out, -1);
    idle(); step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      pe.cfg_we = ($urandom_range(0, 19) == 0);
      pe.cfg_addr = 2'($urandom_range(0, 3));
      pe.cfg_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) pe.mode_local = ~pe.mode_local;
      if ($urandom_range(0, 15) == 0) begin
        pe.V_in = 20'($urandom); pe.F_in = 20'($urandom);
      end else begin
        pe.V_in = 20'($urandom_range(0, 60) - 30); pe.F_in = 20'($urandom_range(0, 60) - 30);
      end
      pe.T_in = 2'($urandom_range(0, 3));
      pe.S_in = 2'($urandom_range(0, 3));
      pe.store_S = ($urandom_range(0, 9) == 0);
      pe.init_in = ($urandom_range(0, 9) < 8);
      pe.last_in = ($urandom_range(0, 7) == 0);
      pe.max_in = 20'($urandom_range(0, 80) - 20);
      pe.pos_in = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sw_pe_cfg.md
SW_PE_CFG -- requirements
Module: sw_pe_cfg

Interface
REQ-001 Parameter WIDTH, 20, signed score width for V, E, F and max.
REQ-002 Parameter SYM_W, 2, symbol width of S and T.
REQ-003 Parameter POS_W, 16, column position counter width.
REQ-004 Parameters MATCH_DEF 2, MISMATCH_DEF -2, GAP_OPEN_DEF -2, GAP_EXT_DEF -1, 8-bit signed reset values of the score registers.
REQ-005 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_we  in  1  score register write strobe.
REQ-007 cfg_addr  in  2  register select: 0 match, 1 mismatch, 2 gap open, 3 gap extend.
REQ-008 cfg_data  in  8  signed write value.
REQ-009 mode_local  in  1  1 = local alignment (zero clamp), 0 = global (no clamp).
REQ-010 V_in, F_in  in  WIDTH  score and left-gap value from the previous PE.
REQ-011 T_in  in  SYM_W  reference symbol shift-in; S_in  in  SYM_W  query symbol; store_S  in  1  latch S_in.
REQ-012 init_in  in  1  computation active; last_in  in  1  final reference column marker.
REQ-013 max_in  in  WIDTH, pos_in  in  POS_W  best score and column from the upstream PE.
REQ-014 V_out, F_out  out  WIDTH; T_out  out  SYM_W; init_out, last_out  out  1; max_out  out  WIDTH; pos_out  out  POS_W.

Function
REQ-015 All outputs SHALL be registered; T_out, init_out and last_out SHALL equal T_in, init_in and last_in delayed by exactly 1 cycle.
REQ-016 S SHALL load S_in on any cycle with store_S=1, independent of init_in.
REQ-017 V_diag SHALL load V_in every non-reset cycle.
REQ-018 Additions SHALL sign-extend the 8-bit score to WIDTH and saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-019 H = V_diag + (S==T_in ? match : mismatch); newE = max(V+gap_open, E+gap_ext); newF = max(V_in+gap_open, F_in+gap_ext); comparisons signed.
REQ-020 With init_in=1: E<=newE, F<=newF; V<=0 if mode_local and newE, newF, H all <0; else newE if newE>newF and newE>H; else newF if newF>H; else H.
REQ-021 With init_in=0: V, E, F SHALL load 0.
REQ-022 col counter SHALL be 0 on the first init_in=1 cycle after init_in=0 and increment by 1 each subsequent init_in=1 cycle, wrapping at 2^POS_W.
REQ-023 best/best_pos SHALL clear to 0 on the first cycle of a pass, then update to the new V and col only when new V > best (strict; ties keep earliest column).
REQ-024 On a cycle with last_in=1: max_out/pos_out SHALL load max_in/pos_in if max_in > the best including this cycle's V, else that best and its column; otherwise max_out/pos_out SHALL hold.
REQ-025 A cfg_we write SHALL take effect from the next cycle, including mid-pass; cfg_addr values outside 0-3 are impossible (2-bit).
REQ-026 Simultaneous last_in and cfg_we: the last cycle SHALL use the old score values.

Reset
REQ-027 rst=1 SHALL clear V, E, F, V_diag, S, T, init, last, col, best, best_pos, max_out and pos_out to 0 and restore score registers to the *_DEF values; rst overrides all other inputs including mid-pass.

Verification
REQ-028 rst pulse mid-pass -> next cycle all outputs 0, score registers 2/-2/-2/-1.
REQ-029 S=A, local, V_in=F_in=0, T stream A,C,A with init_in=1 -> V_out 2,0,2; best 2 at col 0.
REQ-030 WIDTH=8, V_in=126, match on next cycle -> V_out saturates to 127.
REQ-031 S=A, T=C, V_in=F_in=0, E=0 -> mode_local=0 gives V_out -1; mode_local=1 gives 0.
REQ-032 last_in with max_in=5, pos_in=7, own best 2 -> max_out 5, pos_out 7; own best 9 at col 3 -> max_out 9, pos_out 3.
REQ-033 cfg write match=5 mid-pass -> the following matching column adds 5 to V_diag.
